level_column_loader: RTL and testbench
======================================

// Module: level_column_loader
// PURPOSE
//  Upstream feeder for the on-screen block-column array. It fetches the next
//  10-row level column (3-bit block IDs) from the level ROM and presents it on
//  new_block_id. It then pulses Shift for one cycle during vertical blank, so the
//  array scrolls left by one column without tearing. It tracks the level column
//  index and stops at the end of the level.
// PARAMETERS
//  LEVEL_COLS  212  total columns in the level ROM (addresses 0..LEVEL_COLS-1)
//  INIT_COL    10   first column to fetch after reset (columns 0..9 preloaded)
//  ROM_LAT     1    ROM read latency in cycles, rom_addr -> rom_data (1..3)
// PORTS
//  Clk           in   1   system clock
//  Reset         in   1   synchronous, active-high reset
//  scroll_req    in   1   1-cycle pulse: Mario crossed right scroll threshold
//  vblank        in   1   high while the VGA is in vertical blank
//  rom_addr      out  10  level ROM column address
//  rom_data      in   30  ROM column word; [3r+2:3r] = block ID of row r
//  new_block_id  out  30  column to append; stable while Shift is high
//  Shift         out  1   1-cycle pulse: array shifts and captures new_block_id
//  next_col      out  10  index of the next column to be fetched
//  busy          out  1   high in any state other than IDLE
//  level_end     out  1   high once next_col == LEVEL_COLS (sticky until Reset)
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, Shift=0, busy=0, new_block_id=0, rom_addr=INIT_COL
//   - next_col=INIT_COL, pending=0, level_end=(INIT_COL>=LEVEL_COLS)
//  FSM states: IDLE, FETCH, WAIT, HOLD, SHIFT
//   - IDLE: on (scroll_req|pending) & !level_end -> FETCH; clear pending.
//     While level_end is set, requests are dropped.
//   - FETCH: rom_addr=next_col; load the latency counter with ROM_LAT-1 -> WAIT.
//   - WAIT: count down. When the count is 0, register rom_data into
//     new_block_id -> HOLD.
//   - HOLD: wait for vblank=1 -> SHIFT. There is no timeout.
//   - SHIFT: Shift=1 for exactly 1 cycle; next_col<=next_col+1;
//     level_end<=(next_col+1==LEVEL_COLS) -> IDLE.
//  Latency:
//   - With vblank already high, scroll_req to Shift takes ROM_LAT+3 cycles.
//   - Example, ROM_LAT=1: req@t0, FETCH@t1, WAIT@t2, HOLD@t3, Shift@t4.
//  Outputs and bookkeeping:
//   - rom_addr is held at next_col in every state. It changes only after SHIFT.
//   - new_block_id changes only on the WAIT->HOLD capture. It holds otherwise,
//     including through SHIFT and afterwards.
//   - scroll_req while busy sets pending (a 1-deep queue). Further requests
//     while pending=1 are dropped. At most one extra shift is queued.
//   - A scroll_req on the same cycle as SHIFT sets pending. It is serviced
//     from IDLE the next cycle.
//   - Shift is never high on 2 consecutive cycles. The minimum spacing is
//     ROM_LAT+4 cycles.
//   - next_col saturates at LEVEL_COLS. It never wraps.
//  Reset mid-operation:
//   - Abort to the reset values. Shift=0 on the cycle after Reset is sampled.
//   - No partial shift occurs.
//  Widths: next_col+1 is computed in 11 bits for the compare. LEVEL_COLS<=1023.
// TESTING
//  1. Reset, ROM col10=30'h0000_0049, vblank=1, one scroll_req -> Shift@+4cyc,
//     new_block_id=30'h49, next_col=11, rom_addr=11.
//  2. vblank=0 with scroll_req -> FSM holds in HOLD, Shift=0; raise vblank
//     after 100 cycles -> Shift the next cycle, exactly 1 cycle wide.
//  3. Three scroll_req pulses 1 cycle apart -> exactly 2 Shift pulses
//     (cols 10, 11), next_col=12, third request dropped.
//  4. LEVEL_COLS=12 -> after 2 shifts, level_end=1; further scroll_req gives
//     no Shift, busy stays 0, next_col=12.
//  5. Reset asserted in WAIT -> next cycle state=IDLE, Shift=0, next_col=10,
//     pending=0; no Shift ever emitted for the aborted request.
//  6. ROM_LAT=3 -> req-to-Shift=6 cycles; new_block_id matches ROM at addr 10.

Source files
------------

// File: rtl/level_column_loader.sv
// level_column_loader: fetches the next level column from ROM and shifts it into the block array during vblank
// Ports: Clk, Reset (sync, active-high); scroll_req, vblank (in); rom_addr, rom_data (ROM read port);
//        new_block_id, Shift (column + 1-cycle append strobe); next_col, busy, level_end (status).
module level_column_loader #(
    parameter int LEVEL_COLS = 212,
    parameter int INIT_COL   = 10,
    parameter int ROM_LAT    = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        scroll_req,
    input  logic        vblank,
    output logic [9:0]  rom_addr,
    input  logic [29:0] rom_data,
    output logic [29:0] new_block_id,
    output logic        Shift,
    output logic [9:0]  next_col,
    output logic        busy,
    output logic        level_end
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, SHIFT} state_t;
    localparam logic [10:0] LAST     = 11'(LEVEL_COLS);
    localparam logic [9:0]  INIT     = 10'(INIT_COL);
    localparam logic [1:0]  LAT_M1   = 2'(ROM_LAT - 1);
    localparam logic        INIT_END = (INIT_COL >= LEVEL_COLS);
    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        pending_q;
    logic        shift_q;
    logic        busy_q;
    logic        level_end_q;
    logic [9:0]  next_col_q;
    logic [9:0]  rom_addr_q;
    logic [29:0] block_q;
    logic [10:0] col_inc_d;
    logic [9:0]  next_col_d;
    logic        accept_d;
    // 11-bit increment so the end-of-level compare cannot wrap; the column saturates at LEVEL_COLS
    always_comb begin
        col_inc_d  = {1'b0, next_col_q} + 11'd1;
        next_col_d = (col_inc_d >= LAST) ? LAST[9:0] : col_inc_d[9:0];
        accept_d   = (scroll_req | pending_q) & ~level_end_q;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            pending_q   <= 1'b0;
            shift_q     <= 1'b0;
            busy_q      <= 1'b0;
            level_end_q <= INIT_END;
            next_col_q  <= INIT;
            rom_addr_q  <= INIT;
            block_q     <= 30'd0;
        end else begin
            shift_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pending_q <= 1'b0;
                    if (accept_d) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    cnt_q   <= LAT_M1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        block_q <= rom_data;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                HOLD: begin
                    if (vblank) begin
                        state_q <= SHIFT;
                        shift_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    next_col_q  <= next_col_d;
                    rom_addr_q  <= next_col_d;
                    level_end_q <= level_end_q | (col_inc_d >= LAST);
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // one-deep request queue; a request while already pending is dropped
            if (state_q != IDLE && scroll_req) pending_q <= 1'b1;
        end
    end
    assign rom_addr     = rom_addr_q;
    assign new_block_id = block_q;
    assign Shift        = shift_q;
    assign next_col     = next_col_q;
    assign busy         = busy_q;
    assign level_end    = level_end_q;
endmodule

// File: tb/tb_level_column_loader.sv
// tb_level_column_loader: randomized bench for two loader configurations against a timing-level model
module tb_level_column_loader;
    logic        Clk, Reset, scroll_req, vblank;
    logic [9:0]  ra0, nc0, ra1, nc1;
    logic [29:0] rd0, nb0, rd1, nb1;
    logic        sh0, bz0, le0, sh1, bz1, le1;
    logic [29:0] rom [1024];
    logic [29:0] pipe1 [3];
    int checks = 0, failures = 0, cyc = 0, sc0 = 0, base;
    bit mvalid = 0;
    int lat [2] = '{1, 3};
    int lc [2] = '{212, 12};
    bit act_m [2], pend_m [2], lend_m [2];
    int hold_from [2], shift_at [2], ncol_m [2];
    logic [29:0] nbid_m [2];

    level_column_loader #(.LEVEL_COLS(212), .INIT_COL(10), .ROM_LAT(1)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .scroll_req(scroll_req), .vblank(vblank),
        .rom_addr(ra0), .rom_data(rd0), .new_block_id(nb0), .Shift(sh0),
        .next_col(nc0), .busy(bz0), .level_end(le0));
    level_column_loader #(.LEVEL_COLS(12), .INIT_COL(10), .ROM_LAT(3)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .scroll_req(scroll_req), .vblank(vblank),
        .rom_addr(ra1), .rom_data(rd1), .new_block_id(nb1), .Shift(sh1),
        .next_col(nc1), .busy(bz1), .level_end(le1));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        rd0      <= rom[ra0];
        pipe1[0] <= rom[ra1];
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign rd1 = pipe1[2];

    // model: a request accepted in cycle c reaches HOLD at c+LAT+2; Shift follows the first HOLD cycle with vblank
    always @(posedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                act_m[i] = 0; pend_m[i] = 0; shift_at[i] = -1; hold_from[i] = 0;
                ncol_m[i] = 10; lend_m[i] = (10 >= lc[i]); nbid_m[i] = '0;
            end else if (!act_m[i]) begin
                if ((scroll_req || pend_m[i]) && !lend_m[i]) begin
                    act_m[i] = 1; hold_from[i] = cyc + lat[i] + 2; shift_at[i] = -1;
                end
                pend_m[i] = 0;
            end else begin
                if (scroll_req) pend_m[i] = 1;
                if (cyc == shift_at[i]) begin
                    if (ncol_m[i] < lc[i]) ncol_m[i]++;
                    lend_m[i] = (ncol_m[i] >= lc[i]);
                    act_m[i] = 0; shift_at[i] = -1;
                end else if (cyc == hold_from[i] - 1) begin
                    nbid_m[i] = rom[ncol_m[i]];
                end else if (cyc >= hold_from[i] && vblank && shift_at[i] < 0) begin
                    shift_at[i] = cyc + 1;
                end
            end
        end
        if (Reset) mvalid = 1;
        cyc++;
    end

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (sh0) sc0++;
        if (mvalid) begin
            cmp("m0.Shift", 32'(sh0), 32'(act_m[0] && shift_at[0] == cyc));
            cmp("m0.busy", 32'(bz0), 32'(act_m[0]));
            cmp("m0.next_col", 32'(nc0), 32'(ncol_m[0]));
            cmp("m0.rom_addr", 32'(ra0), 32'(ncol_m[0]));
            cmp("m0.level_end", 32'(le0), 32'(lend_m[0]));
            cmp("m0.new_block_id", 32'(nb0), 32'(nbid_m[0]));
            cmp("m1.Shift", 32'(sh1), 32'(act_m[1] && shift_at[1] == cyc));
            cmp("m1.busy", 32'(bz1), 32'(act_m[1]));
            cmp("m1.next_col", 32'(nc1), 32'(ncol_m[1]));
            cmp("m1.rom_addr", 32'(ra1), 32'(ncol_m[1]));
            cmp("m1.level_end", 32'(le1), 32'(lend_m[1]));
            cmp("m1.new_block_id", 32'(nb1), 32'(nbid_m[1]));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = 30'($urandom);
        rom[10] = 30'h0000_0049;
        Reset = 1; scroll_req = 0; vblank = 0;
        step(); step();
        Reset = 0; vblank = 1;
        step();
        cmp("rst.next_col", 32'(nc0), 32'd10);
        cmp("rst.rom_addr", 32'(ra0), 32'd10);
        cmp("rst.busy", 32'(bz0), 32'd0);
        cmp("rst.Shift", 32'(sh0), 32'd0);
        cmp("rst.new_block_id", 32'(nb0), 32'd0);
        cmp("rst.level_end", 32'(le1), 32'd0);
        // single request, vblank high: Shift 4 cycles later (ROM_LAT=1), 6 cycles later (ROM_LAT=3)
        scroll_req = 1; step(); scroll_req = 0;
        step(); step();
        cmp("lat1.early_shift", 32'(sh0), 32'd0);
        step();
        cmp("lat1.shift", 32'(sh0), 32'd1);
        cmp("lat1.block", 32'(nb0), 32'h49);
        step();
        cmp("lat1.shift_width", 32'(sh0), 32'd0);
        cmp("lat1.next_col", 32'(nc0), 32'd11);
        cmp("lat1.rom_addr", 32'(ra0), 32'd11);
        cmp("lat3.early_shift", 32'(sh1), 32'd0);
        step();
        cmp("lat3.shift", 32'(sh1), 32'd1);
        cmp("lat3.block", 32'(nb1), 32'h49);
        step();
        cmp("lat3.next_col", 32'(nc1), 32'd11);
        repeat (5) step();
        // no vblank: park in HOLD for 100 cycles
        vblank = 0; scroll_req = 1; step(); scroll_req = 0;
        repeat (100) step();
        cmp("hold.Shift", 32'(sh0), 32'd0);
        cmp("hold.busy", 32'(bz0), 32'd1);
        vblank = 1; step();
        cmp("hold.release0", 32'(sh0), 32'd1);
        cmp("hold.release1", 32'(sh1), 32'd1);
        step();
        cmp("hold.width", 32'(sh0), 32'd0);
        cmp("hold.next_col", 32'(nc0), 32'd12);
        cmp("end.level_end", 32'(le1), 32'd1);
        cmp("end.next_col", 32'(nc1), 32'd12);
        // ended instance ignores requests
        scroll_req = 1; step(); scroll_req = 0;
        cmp("end.busy", 32'(bz1), 32'd0);
        repeat (10) step();
        cmp("end.next_col_hold", 32'(nc1), 32'd12);
        cmp("end.busy_hold", 32'(bz1), 32'd0);
        cmp("m0.after_end_req", 32'(nc0), 32'd13);
        // three back-to-back requests: one serviced, one queued, one dropped
        base = sc0;
        scroll_req = 1; step(); step(); step(); scroll_req = 0;
        repeat (30) step();
        cmp("queue.shifts", 32'(sc0 - base), 32'd2);
        cmp("queue.next_col", 32'(nc0), 32'd15);
        // reset while in WAIT aborts without a shift
        base = sc0;
        scroll_req = 1; step(); scroll_req = 0; step();
        Reset = 1; step(); Reset = 0;
        cmp("abort.Shift", 32'(sh0), 32'd0);
        cmp("abort.busy", 32'(bz0), 32'd0);
        cmp("abort.next_col", 32'(nc0), 32'd10);
        repeat (20) step();
        cmp("abort.no_shift", 32'(sc0 - base), 32'd0);
        // random traffic
        repeat (3000) begin
            scroll_req = ($urandom_range(0, 3) == 0);
            vblank = ($urandom_range(0, 2) != 0);
            Reset = ($urandom_range(0, 599) == 0);
            step();
        end
        // run instance 0 to the end of the level
        Reset = 0; vblank = 1; scroll_req = 1;
        repeat (1500) step();
        scroll_req = 0;
        repeat (10) step();
        cmp("final.next_col", 32'(nc0), 32'd212);
        cmp("final.rom_addr", 32'(ra0), 32'd212);
        cmp("final.level_end", 32'(le0), 32'd1);
        cmp("final.busy", 32'(bz0), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
